alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Hardwired control sequencer for the datapath's register-to-register and immediate ALU instructions. It fetches each instruction through PC/MAR/MDR/IR, decodes the IR fields, and steps the datapath through T0–T6 by driving the same bus-out, enable and op_code strobes the datapath already exposes. It replaces hand-sequenced stimulus and sits between instruction memory and the `Datapath` control inputs.

## Interface
- `STEP_CYCLES`, 2, clocks spent in each T-state (1..15)
- `clk`  in  1  system clock, rising edge
- `clr`  in  1  reset, asynchronous, active-low
- `start`  in  1  level: run instructions while high
- `mem_ready`  in  1  memory data valid for the MDR load in T1
- `ir`  in  32  IR contents: [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc
- `pc_out`, `zlo_out`, `zhi_out`, `mdr_out`, `c_out`  out  1  bus drivers
- `mar_enable`, `mdr_enable`, `ir_enable`, `y_enable`, `z_enable`, `pc_enable`, `lo_enable`, `hi_enable`  out  1  register load strobes
- `pc_increment`, `read`  out  1  PC step, MDR mux selects memory
- `reg_out`, `reg_in`  out  1  general register drives bus / loads from bus
- `rsel`  out  4  general register selected for `reg_out`/`reg_in`
- `op_code`  out  5  ALU operation
- `done`  out  1  one-cycle pulse on instruction retire
- `illegal`  out  1  one-cycle pulse on unsupported opcode

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6. Registered Moore outputs.
- Bus drivers, `read`, `rsel`, `op_code` are held for the whole dwell. Load strobes, `pc_increment`, `done` and `illegal` assert only in the last dwell cycle. This guarantees exactly one load or increment per state.
- IDLE: all outputs 0. Enter T0 when `start`=1.
- T0: `pc_out`, `mar_enable`, `pc_increment`.
- T1: `read`, `mdr_enable`. The dwell counter freezes at the last cycle, with strobes deasserted, until `mem_ready`=1.
- T2: `mdr_out`, `ir_enable`. The opcode is decoded from `ir` on entry to T3.
- Three-register ops (add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011):
  - T3: `reg_out`, `rsel`=Rb, `y_enable`.
  - T4: `reg_out`, `rsel`=Rc, `op_code`=opcode, `z_enable`.
  - T5: `zlo_out`, `reg_in`, `rsel`=Ra.
- Immediate ops (addi 01100, andi 01101, ori 01110): same as three-register ops, except T4 drives `c_out` instead of `reg_out`.
- Unary ops (neg 10001, not 10010):
  - T3: no outputs active.
  - T4: `reg_out`, `rsel`=Rb, `op_code`, `z_enable`.
  - T5: writes Ra.
- mul 10000, div 01111:
  - T3: Y←Ra.
  - T4: Rb to ALU, `z_enable`.
  - T5: `zlo_out`, `lo_enable`.
  - T6: `zhi_out`, `hi_enable`.
- Retire: `done` pulses in the last cycle of the final state (T5 or T6). The next state is T0 if `start`=1, else IDLE.
- Illegal: opcodes ld/ldi/st (00000–00010) and ≥10011. In T3 assert `illegal` on its last dwell cycle with no other outputs, then go to IDLE regardless of `start`.
- `op_code` reads 0 outside T4.

## Timing
- Reset (`clr`=0) acts immediately: state IDLE, dwell counter 0, every output 0.
- Reset asserted mid-instruction aborts it with no `done` pulse. Partially loaded datapath registers are left as they are.
- Latency from T0 entry to `done`, with zero memory wait:
  - 6×`STEP_CYCLES` for three-register, immediate and unary ops.
  - 7×`STEP_CYCLES` for mul/div.
  - Each cycle of `mem_ready`=0 in the final T1 cycle adds 1.
- Back-to-back instructions: T0 follows the retire cycle directly, with no IDLE gap.
- `start` dropping mid-instruction does not abort. The instruction completes, then the block goes to IDLE.
- `ir` is only sampled on T2→T3 and must stay stable through T5/T6.

## Configuration
- `ALU_SEQ_MULDIV_EN` defined: mul/div are sequenced through T6 as above.
- Undefined:
  - T6 and `lo_enable`/`hi_enable`/`zhi_out` logic are removed, and those outputs are tied to 0.
  - Opcodes 10000 and 01111 are treated as illegal.

## Test plan
- shl, STEP=2: `ir`=0x5A1B8000 (Ra=4, Rb=3, Rc=7), `start`=1, `mem_ready`=1 → T3 `rsel`=3 with `y_enable`, T4 `rsel`=7 with `op_code`=01011, T5 `reg_in` with `rsel`=4. `done` at cycle 12 after T0 entry; exactly one `pc_increment` pulse.
- mul, with macro defined: `ir`=0x80A00000 → T5 `lo_enable`, T6 `hi_enable`, `done` at cycle 14. Without the macro: `illegal` pulse in T3, then IDLE.
- Memory wait: hold `mem_ready`=0 for 5 cycles in T1 → `mdr_enable` pulses once, after `mem_ready` rises; `done` is delayed by exactly 5 cycles.
- addi 0x61100000 → T4 has `c_out`=1 and `reg_out`=0; `st` 0x10000000 → `illegal` pulse, IDLE, no `done`.
- Reset: drive `clr`=0 during T4 with `z_enable` high → all outputs 0 in the same cycle, no `done`. After release with `start`=1 → fresh T0.
- `start` dropped during T3 → current instruction retires with `done`, then IDLE, and no T0 follows.

Source files
------------

// File: rtl/alu_seq_ctrl_if.sv
// Control bundle between the ALU sequencer and its environment: start/memory/IR inputs
// and the bus-out, load-strobe and op_code signals driven into the datapath.
interface alu_seq_ctrl_if;
  logic        start;
  logic        mem_ready;
  logic [31:0] ir;
  logic        pc_out, zlo_out, zhi_out, mdr_out, c_out;
  logic        mar_enable, mdr_enable, ir_enable, y_enable, z_enable;
  logic        pc_enable, lo_enable, hi_enable;
  logic        pc_increment, read, reg_out, reg_in;
  logic [3:0]  rsel;
  logic [4:0]  op_code;
  logic        done, illegal;

  modport master (
    output start, mem_ready, ir,
    input  pc_out, zlo_out, zhi_out, mdr_out, c_out,
    input  mar_enable, mdr_enable, ir_enable, y_enable, z_enable,
    input  pc_enable, lo_enable, hi_enable,
    input  pc_increment, read, reg_out, reg_in, rsel, op_code, done, illegal
  );

  modport slave (
    input  start, mem_ready, ir,
    output pc_out, zlo_out, zhi_out, mdr_out, c_out,
    output mar_enable, mdr_enable, ir_enable, y_enable, z_enable,
    output pc_enable, lo_enable, hi_enable,
    output pc_increment, read, reg_out, reg_in, rsel, op_code, done, illegal
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Hardwired T0-T6 control sequencer for register, immediate and unary ALU instructions.
// Define ALU_SEQ_MULDIV_EN to also sequence mul/div through T6 into the LO/HI registers.
module alu_seq_ctrl #(
  parameter int STEP_CYCLES = 2
) (
  input  logic          clk,
  input  logic          clr,
  alu_seq_ctrl_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6} state_e;
  typedef enum logic [2:0] {C_RRR, C_IMM, C_UN, C_MD, C_ILL} cls_e;

  typedef struct packed {
    logic       pc_out;
    logic       zlo_out;
    logic       mdr_out;
    logic       c_out;
    logic       mar_enable;
    logic       mdr_enable;
    logic       ir_enable;
    logic       y_enable;
    logic       z_enable;
`ifdef ALU_SEQ_MULDIV_EN
    logic       zhi_out;
    logic       lo_enable;
    logic       hi_enable;
`endif
    logic       pc_increment;
    logic       read;
    logic       reg_out;
    logic       reg_in;
    logic [3:0] rsel;
    logic [4:0] op_code;
    logic       done;
    logic       illegal;
  } ctrl_t;

  localparam logic [3:0] LAST = 4'(STEP_CYCLES - 1);

  state_e     state_q, state_d;
  cls_e       cls_q, cls_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] opc_q, opc_d;
  ctrl_t      out_q, out_d;
  logic       last_q, last_d;
  logic [3:0] ra, rb, rc;

  assign ra     = bus.ir[26:23];
  assign rb     = bus.ir[22:19];
  assign rc     = bus.ir[18:15];
  assign last_q = (cnt_q == LAST);
  assign last_d = (cnt_d == LAST);

  function automatic cls_e decode(input logic [4:0] op);
    cls_e c;
    if (op >= 5'd3 && op <= 5'd11)       c = C_RRR;
    else if (op >= 5'd12 && op <= 5'd14) c = C_IMM;
    else if (op == 5'd17 || op == 5'd18) c = C_UN;
`ifdef ALU_SEQ_MULDIV_EN
    else if (op == 5'd15 || op == 5'd16) c = C_MD;
`endif
    else                                 c = C_ILL;
    return c;
  endfunction

  // T1 leaves its last dwell cycle only once the registered MDR load has actually fired.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cls_d   = cls_q;
    opc_d   = opc_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_T0;
          cnt_d   = '0;
        end
      end
      S_T1: begin
        if (!last_q) begin
          cnt_d = cnt_q + 4'd1;
        end else if (out_q.mdr_enable) begin
          state_d = S_T2;
          cnt_d   = '0;
        end
      end
      default: begin
        if (!last_q) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = '0;
          case (state_q)
            S_T0: state_d = S_T1;
            S_T2: begin
              state_d = S_T3;
              cls_d   = decode(bus.ir[31:27]);
              opc_d   = bus.ir[31:27];
            end
            S_T3: begin
              if (cls_q == C_ILL) state_d = S_IDLE;
              else                state_d = S_T4;
            end
            S_T4: state_d = S_T5;
`ifdef ALU_SEQ_MULDIV_EN
            S_T5: begin
              if (cls_q == C_MD)  state_d = S_T6;
              else if (bus.start) state_d = S_T0;
              else                state_d = S_IDLE;
            end
            S_T6: begin
              if (bus.start) state_d = S_T0;
              else           state_d = S_IDLE;
            end
`else
            S_T5: begin
              if (bus.start) state_d = S_T0;
              else           state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so that they register in step with it.
  always_comb begin
    out_d = '0;
    case (state_d)
      S_T0: begin
        out_d.pc_out       = 1'b1;
        out_d.mar_enable   = last_d;
        out_d.pc_increment = last_d;
      end
      S_T1: begin
        out_d.read       = 1'b1;
        out_d.mdr_enable = last_d && bus.mem_ready;
      end
      S_T2: begin
        out_d.mdr_out   = 1'b1;
        out_d.ir_enable = last_d;
      end
      S_T3: begin
        case (cls_d)
          C_RRR, C_IMM: begin
            out_d.reg_out  = 1'b1;
            out_d.rsel     = rb;
            out_d.y_enable = last_d;
          end
`ifdef ALU_SEQ_MULDIV_EN
          C_MD: begin
            out_d.reg_out  = 1'b1;
            out_d.rsel     = ra;
            out_d.y_enable = last_d;
          end
`endif
          C_ILL:   out_d.illegal = last_d;
          default: ;
        endcase
      end
      S_T4: begin
        out_d.op_code  = opc_d;
        out_d.z_enable = last_d;
        case (cls_d)
          C_RRR: begin
            out_d.reg_out = 1'b1;
            out_d.rsel    = rc;
          end
          C_IMM: begin
            out_d.c_out = 1'b1;
            out_d.rsel  = rc;
          end
          default: begin
            out_d.reg_out = 1'b1;
            out_d.rsel    = rb;
          end
        endcase
      end
      S_T5: begin
        out_d.zlo_out = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
        if (cls_d == C_MD) begin
          out_d.lo_enable = last_d;
        end else begin
          out_d.reg_in = 1'b1;
          out_d.rsel   = ra;
          out_d.done   = last_d;
        end
`else
        out_d.reg_in = 1'b1;
        out_d.rsel   = ra;
        out_d.done   = last_d;
`endif
      end
`ifdef ALU_SEQ_MULDIV_EN
      S_T6: begin
        out_d.zhi_out   = 1'b1;
        out_d.hi_enable = last_d;
        out_d.done      = last_d;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cls_q   <= C_ILL;
      opc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cls_q   <= cls_d;
      opc_q   <= opc_d;
      out_q   <= out_d;
    end
  end

  assign bus.pc_out       = out_q.pc_out;
  assign bus.zlo_out      = out_q.zlo_out;
  assign bus.mdr_out      = out_q.mdr_out;
  assign bus.c_out        = out_q.c_out;
  assign bus.mar_enable   = out_q.mar_enable;
  assign bus.mdr_enable   = out_q.mdr_enable;
  assign bus.ir_enable    = out_q.ir_enable;
  assign bus.y_enable     = out_q.y_enable;
  assign bus.z_enable     = out_q.z_enable;
  assign bus.pc_enable    = 1'b0;
  assign bus.pc_increment = out_q.pc_increment;
  assign bus.read         = out_q.read;
  assign bus.reg_out      = out_q.reg_out;
  assign bus.reg_in       = out_q.reg_in;
  assign bus.rsel         = out_q.rsel;
  assign bus.op_code      = out_q.op_code;
  assign bus.done         = out_q.done;
  assign bus.illegal      = out_q.illegal;
`ifdef ALU_SEQ_MULDIV_EN
  assign bus.zhi_out      = out_q.zhi_out;
  assign bus.lo_enable    = out_q.lo_enable;
  assign bus.hi_enable    = out_q.hi_enable;
`else
  assign bus.zhi_out      = 1'b0;
  assign bus.lo_enable    = 1'b0;
  assign bus.hi_enable    = 1'b0;
`endif
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: per-cycle comparison of every output against a schedule model
// built from the instruction class, dwell length and memory wait.
module tb_alu_seq_ctrl;
  localparam int S = 2;
`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  typedef struct packed {
    logic       pc_out, zlo_out, zhi_out, mdr_out, c_out;
    logic       mar_enable, mdr_enable, ir_enable, y_enable, z_enable;
    logic       pc_enable, lo_enable, hi_enable;
    logic       pc_increment, read, reg_out, reg_in;
    logic [3:0] rsel;
    logic [4:0] op_code;
    logic       done, illegal;
  } ov_t;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_seq_ctrl_if bus ();
  alu_seq_ctrl #(.STEP_CYCLES(S)) dut (.clk(clk), .clr(clr), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic ov_t sample();
    ov_t o;
    o.pc_out = bus.pc_out;         o.zlo_out = bus.zlo_out;       o.zhi_out = bus.zhi_out;
    o.mdr_out = bus.mdr_out;       o.c_out = bus.c_out;           o.mar_enable = bus.mar_enable;
    o.mdr_enable = bus.mdr_enable; o.ir_enable = bus.ir_enable;   o.y_enable = bus.y_enable;
    o.z_enable = bus.z_enable;     o.pc_enable = bus.pc_enable;   o.lo_enable = bus.lo_enable;
    o.hi_enable = bus.hi_enable;   o.pc_increment = bus.pc_increment;
    o.read = bus.read;             o.reg_out = bus.reg_out;       o.reg_in = bus.reg_in;
    o.rsel = bus.rsel;             o.op_code = bus.op_code;       o.done = bus.done;
    o.illegal = bus.illegal;
    return o;
  endfunction

  // 0 three-register, 1 immediate, 2 unary, 3 mul/div, 4 illegal
  function automatic int kind_of(logic [4:0] op);
    if (op >= 5'd3 && op <= 5'd11) return 0;
    if (op >= 5'd12 && op <= 5'd14) return 1;
    if (op == 5'd17 || op == 5'd18) return 2;
    if (op == 5'd15 || op == 5'd16) return MD_EN ? 3 : 4;
    return 4;
  endfunction

  function automatic int nsteps(int k);
    return (k == 3) ? 7 : ((k == 4) ? 4 : 6);
  endfunction

  function automatic int ilen(logic [31:0] ins, int w);
    return nsteps(kind_of(ins[31:27])) * S + w;
  endfunction

  // Expected outputs t cycles after T0 entry, with w stall cycles in T1.
  function automatic ov_t model(logic [31:0] ins, int t, int w);
    ov_t        o;
    int         k, rem, st, d;
    bit         lst;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    o = '0; op = ins[31:27]; ra = ins[26:23]; rb = ins[22:19]; rc = ins[18:15];
    k = kind_of(op); rem = t; st = -1; lst = 1'b0;
    for (int i = 0; i < nsteps(k); i++) begin
      d = S + ((i == 1) ? w : 0);
      if (st < 0) begin
        if (rem < d) begin st = i; lst = (rem == d - 1); end
        else rem -= d;
      end
    end
    case (st)
      0: begin o.pc_out = 1; o.mar_enable = lst; o.pc_increment = lst; end
      1: begin o.read = 1; o.mdr_enable = lst; end
      2: begin o.mdr_out = 1; o.ir_enable = lst; end
      3: begin
        if (k <= 1)      begin o.reg_out = 1; o.rsel = rb; o.y_enable = lst; end
        else if (k == 3) begin o.reg_out = 1; o.rsel = ra; o.y_enable = lst; end
        else if (k == 4) o.illegal = lst;
      end
      4: begin
        o.op_code = op; o.z_enable = lst;
        if (k == 0)      begin o.reg_out = 1; o.rsel = rc; end
        else if (k == 1) begin o.c_out = 1; o.rsel = rc; end
        else             begin o.reg_out = 1; o.rsel = rb; end
      end
      5: begin
        o.zlo_out = 1;
        if (k == 3) o.lo_enable = lst;
        else begin o.reg_in = 1; o.rsel = ra; end
      end
      6: begin o.zhi_out = 1; o.hi_enable = lst; end
      default: ;
    endcase
    o.done = (st == nsteps(k) - 1) && lst && (k != 4);
    return o;
  endfunction

  // mem_ready to present at the edge that begins cycle t of an instruction.
  function automatic logic mr_for(int t, int w);
    if (t >= 2*S - 1 && t <= 2*S - 2 + w) return 1'b0;
    if (t == 2*S - 1 + w) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic test_reset();
    ov_t got;
    bus.start = 0; bus.mem_ready = 0; bus.ir = '0;
    #2;
    got = sample(); checks++;
    if (got !== '0) begin errors++; $display("FAIL reset_hold got=%h exp=0", got); end
    @(posedge clk); #1; clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      got = sample(); checks++;
      if (got !== '0) begin errors++; $display("FAIL idle_no_start cyc=%0d got=%h exp=0", i, got); end
    end
  endtask

  task automatic test_shl();
    logic [31:0] ins = 32'h5A1B8000;
    ov_t got, exp;
    int L, pcinc, done_at;
    L = ilen(ins, 0); pcinc = 0; done_at = -1;
    bus.ir = ins; bus.start = 1; bus.mem_ready = mr_for(0, 0);
    for (int t = 0; t < L; t++) begin
      @(posedge clk); #1;
      got = sample(); exp = model(ins, t, 0); checks++;
      if (got !== exp) begin errors++; $display("FAIL shl t=%0d got=%h exp=%h", t, got, exp); end
      if (got.pc_increment) pcinc++;
      if (got.done) done_at = t;
      bus.mem_ready = mr_for(t + 1, 0);
      if (t == L - 1) bus.start = 0;
    end
    checks++;
    if (done_at !== 6*S - 1) begin errors++; $display("FAIL shl_done_cycle got=%0d exp=%0d", done_at, 6*S - 1); end
    checks++;
    if (pcinc !== 1) begin errors++; $display("FAIL shl_pc_increment got=%0d exp=1", pcinc); end
    @(posedge clk); #1;
    got = sample(); checks++;
    if (got !== '0) begin errors++; $display("FAIL shl_then_idle got=%h exp=0", got); end
  endtask

  task automatic test_mem_wait();
    logic [31:0] ins;
    ov_t got, exp;
    int L, w, mdr_cnt, mdr_at, done_at;
    ins = {5'd4, 27'($urandom)}; w = 5;
    L = ilen(ins, w); mdr_cnt = 0; mdr_at = -1; done_at = -1;
    bus.ir = ins; bus.start = 1; bus.mem_ready = mr_for(0, w);
    for (int t = 0; t < L; t++) begin
      @(posedge clk); #1;
      got = sample(); exp = model(ins, t, w); checks++;
      if (got !== exp) begin errors++; $display("FAIL memwait t=%0d got=%h exp=%h", t, got, exp); end
      if (got.mdr_enable) begin mdr_cnt++; mdr_at = t; end
      if (got.done) done_at = t;
      bus.mem_ready = mr_for(t + 1, w);
      if (t == L - 1) bus.start = 0;
    end
    checks++;
    if (mdr_cnt !== 1 || mdr_at !== 2*S - 1 + w) begin
      errors++; $display("FAIL memwait_mdr count=%0d at=%0d exp count=1 at=%0d", mdr_cnt, mdr_at, 2*S - 1 + w);
    end
    checks++;
    if (done_at !== 6*S - 1 + w) begin errors++; $display("FAIL memwait_done got=%0d exp=%0d", done_at, 6*S - 1 + w); end
    @(posedge clk); #1;
  endtask

  task automatic test_addi_st();
    logic [31:0] ins;
    ov_t got, exp;
    int L;
    bit saw_ill, saw_done, saw_c;
    saw_c = 0;
    ins = 32'h61100000; L = ilen(ins, 0);
    bus.ir = ins; bus.start = 1; bus.mem_ready = mr_for(0, 0);
    for (int t = 0; t < L; t++) begin
      @(posedge clk); #1;
      got = sample(); exp = model(ins, t, 0); checks++;
      if (got !== exp) begin errors++; $display("FAIL addi t=%0d got=%h exp=%h", t, got, exp); end
      if (got.z_enable && got.c_out && !got.reg_out) saw_c = 1;
      bus.mem_ready = mr_for(t + 1, 0);
      if (t == L - 1) bus.ir = 32'h10000000;
    end
    checks++;
    if (!saw_c) begin errors++; $display("FAIL addi_c_out got=0 exp=1"); end
    ins = 32'h10000000; L = ilen(ins, 0); saw_ill = 0; saw_done = 0;
    for (int t = 0; t < L; t++) begin
      @(posedge clk); #1;
      got = sample(); exp = model(ins, t, 0); checks++;
      if (got !== exp) begin errors++; $display("FAIL st t=%0d got=%h exp=%h", t, got, exp); end
      if (got.illegal) saw_ill = 1;
      if (got.done) saw_done = 1;
      bus.mem_ready = mr_for(t + 1, 0);
    end
    checks++;
    if (!saw_ill || saw_done) begin errors++; $display("FAIL st_flags illegal=%0d done=%0d exp illegal=1 done=0", saw_ill, saw_done); end
    @(posedge clk); #1;
    bus.start = 0;
    got = sample(); checks++;
    if (got !== '0) begin errors++; $display("FAIL st_to_idle got=%h exp=0", got); end
    @(posedge clk); #1;
    got = sample(); checks++;
    if (got !== '0) begin errors++; $display("FAIL st_stay_idle got=%h exp=0", got); end
  endtask

  task automatic test_mul();
    logic [31:0] ins = 32'h80A00000;
    ov_t got, exp;
    int L, done_at;
    L = ilen(ins, 0); done_at = -1;
    bus.ir = ins; bus.start = 1; bus.mem_ready = mr_for(0, 0);
    for (int t = 0; t < L; t++) begin
      @(posedge clk); #1;
      got = sample(); exp = model(ins, t, 0); checks++;
      if (got !== exp) begin errors++; $display("FAIL mul t=%0d got=%h exp=%h", t, got, exp); end
      if (got.done) done_at = t;
      bus.mem_ready = mr_for(t + 1, 0);
      if (t == L - 1) bus.start = 0;
    end
    checks++;
    if (done_at !== (MD_EN ? 7*S - 1 : -1)) begin
      errors++; $display("FAIL mul_done_cycle got=%0d exp=%0d", done_at, MD_EN ? 7*S - 1 : -1);
    end
    @(posedge clk); #1;
    got = sample(); checks++;
    if (got !== '0) begin errors++; $display("FAIL mul_then_idle got=%h exp=0", got); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ins;
    ov_t got, exp;
    int L;
    ins = {5'd5, 27'($urandom)};
    bus.ir = ins; bus.start = 1; bus.mem_ready = mr_for(0, 0);
    for (int t = 0; t < 5*S; t++) begin
      @(posedge clk); #1;
      got = sample(); exp = model(ins, t, 0); checks++;
      if (got !== exp) begin errors++; $display("FAIL rstmid_pre t=%0d got=%h exp=%h", t, got, exp); end
      bus.mem_ready = mr_for(t + 1, 0);
    end
    checks++;
    if (bus.z_enable !== 1'b1) begin errors++; $display("FAIL rstmid_zen got=%b exp=1", bus.z_enable); end
    #1 clr = 1'b0;
    #1;
    got = sample(); checks++;
    if (got !== '0) begin errors++; $display("FAIL rstmid_immediate got=%h exp=0", got); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      got = sample(); checks++;
      if (got !== '0) begin errors++; $display("FAIL rstmid_held cyc=%0d got=%h exp=0", i, got); end
    end
    ins = {5'd9, 27'($urandom)}; L = ilen(ins, 0);
    bus.ir = ins; bus.start = 1; clr = 1'b1;
    for (int t = 0; t < L; t++) begin
      @(posedge clk); #1;
      got = sample(); exp = model(ins, t, 0); checks++;
      if (got !== exp) begin errors++; $display("FAIL rstmid_fresh t=%0d got=%h exp=%h", t, got, exp); end
      bus.mem_ready = mr_for(t + 1, 0);
      if (t == L - 1) bus.start = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_drop();
    logic [31:0] ins;
    ov_t got, exp;
    int L;
    ins = {5'd17, 27'($urandom)}; L = ilen(ins, 1);
    bus.ir = ins; bus.start = 1; bus.mem_ready = mr_for(0, 1);
    for (int t = 0; t < L; t++) begin
      @(posedge clk); #1;
      got = sample(); exp = model(ins, t, 1); checks++;
      if (got !== exp) begin errors++; $display("FAIL drop t=%0d got=%h exp=%h", t, got, exp); end
      bus.mem_ready = mr_for(t + 1, 1);
      if (t == 3*S + 1) bus.start = 0;
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      got = sample(); checks++;
      if (got !== '0) begin errors++; $display("FAIL drop_idle cyc=%0d got=%h exp=0", i, got); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins;
    ov_t got, exp;
    int L, w;
    ins = $urandom; w = $urandom_range(0, 3);
    bus.ir = ins; bus.start = 1; bus.mem_ready = mr_for(0, w);
    for (int n = 0; n < 40; n++) begin
      L = ilen(ins, w);
      for (int t = 0; t < L; t++) begin
        @(posedge clk); #1;
        got = sample(); exp = model(ins, t, w); checks++;
        if (got !== exp) begin errors++; $display("FAIL b2b n=%0d ir=%h w=%0d t=%0d got=%h exp=%h", n, ins, w, t, got, exp); end
        bus.mem_ready = mr_for(t + 1, w);
        if (t == L - 1 && n == 39) bus.start = 0;
      end
      if (kind_of(ins[31:27]) == 4) begin
        @(posedge clk); #1;
        got = sample(); checks++;
        if (got !== '0) begin errors++; $display("FAIL b2b_illegal_idle n=%0d got=%h exp=0", n, got); end
      end
      ins = $urandom; w = $urandom_range(0, 3);
      bus.ir = ins;
    end
    @(posedge clk); #1;
    got = sample(); checks++;
    if (got !== '0) begin errors++; $display("FAIL b2b_final_idle got=%h exp=0", got); end
  endtask

  initial begin
    test_reset();
    test_shl();
    test_mem_wait();
    test_addi_st();
    test_mul();
    test_reset_mid();
    test_start_drop();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
